// File: rtl/echo_seq_pkg.sv
// echo_seq_pkg: shared FSM states, mode encodings and index-width helper for the echo sequencer
package echo_seq_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GUARD, WAIT, DONE} state_t;
  localparam logic MODE_ADAPT = 1'b1;
  localparam logic MODE_CANCEL = 1'b0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sampling_counter.sv
// sampling_counter: free-running frame counter with wrap pulse; lengths below 2 behave as 2
module sampling_counter #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] sampling_cycle,
  output logic [CNT_W-1:0] count,
  output logic             light
);
  logic [CNT_W-1:0] count_q, count_d, last;
  logic light_q, light_d;
  always_comb begin
    last = (sampling_cycle < CNT_W'(2)) ? CNT_W'(1) : sampling_cycle - CNT_W'(1);
    light_d = count_q >= last;
    count_d = light_d ? '0 : count_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      light_q <= 1'b0;
    end else begin
      count_q <= count_d;
      light_q <= light_d;
    end
  end
  assign count = count_q;
  assign light = light_q;
endmodule

// File: rtl/echo_pipeline_sequencer.sv
// echo_pipeline_sequencer: per-frame walk of the stage chain with enable pulses, ready wait and timeout
module echo_pipeline_sequencer
  import echo_seq_pkg::*;
#(
  parameter int                  N_STAGES    = 5,
  parameter int                  CNT_W       = 13,
  parameter int                  PULSE_LEN   = 2,
  parameter int                  TIMEOUT     = 2048,
  parameter logic [N_STAGES-1:0] ADAPT_MASK  = 5'b11111,
  parameter logic [N_STAGES-1:0] CANCEL_MASK = 5'b10111
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                run,
  input  logic                mode,
  input  logic [CNT_W-1:0]    sampling_cycle,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [CNT_W-1:0]    sampling_cycle_counter,
  output logic                sampling_light,
  output logic [N_STAGES-1:0] stage_enable,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err,
  output logic [3:0]          err_stage,
  output logic                overrun,
  output logic [31:0]         frame_count
);
  localparam int IW = idx_w(N_STAGES);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [N_STAGES-1:0] pending_q, pending_d, stage_enable_q, stage_enable_d;
  logic [IW-1:0] idx_q, idx_d, nxt;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] err_stage_q, err_stage_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
  logic overrun_q, overrun_d, found, frame_start;
  sampling_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk            (clk_operation),
    .rst            (rst),
    .sampling_cycle (sampling_cycle),
    .count          (sampling_cycle_counter),
    .light          (sampling_light)
  );
  assign frame_start = (sampling_cycle_counter == '0) && run;
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    idx_d = idx_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_stage_d = err_stage_q;
    frame_count_d = frame_count_q;
    timeout_err_d = 1'b0;
    overrun_d = frame_start && (state_q != IDLE);
    found = 1'b0;
    nxt = '0;
    // descending scan leaves the lowest pending stage in nxt
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found = 1'b1;
        nxt = IW'(i);
      end
    end
    case (state_q)
      IDLE: if (frame_start) begin
        pending_d = (mode == MODE_ADAPT) ? ADAPT_MASK : CANCEL_MASK;
        state_d = SELECT;
      end
      SELECT: if (found) begin
        idx_d = nxt;
        pending_d[nxt] = 1'b0;
        pulse_cnt_d = '0;
        state_d = PULSE;
      end else begin
        frame_count_d = frame_count_q + 32'd1;
        state_d = DONE;
      end
      PULSE: begin
        pulse_cnt_d = pulse_cnt_q + PW'(1);
        state_d = (pulse_cnt_q == PW'(PULSE_LEN - 1)) ? GUARD : PULSE;
      end
      GUARD: begin
        wait_cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (stage_ready[idx_q]) begin
        state_d = SELECT;
      end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
        timeout_err_d = 1'b1;
        err_stage_d = 4'(idx_q);
        state_d = IDLE;
      end else begin
        wait_cnt_d = wait_cnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
    stage_enable_d = (state_d == PULSE) ? N_STAGES'(1) << idx_d : '0;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    frame_done_d = state_d == DONE;
  end
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      idx_q <= '0;
      pulse_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_stage_q <= '0;
      frame_count_q <= '0;
      stage_enable_q <= '0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      idx_q <= idx_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_stage_q <= err_stage_d;
      frame_count_q <= frame_count_d;
      stage_enable_q <= stage_enable_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      overrun_q <= overrun_d;
    end
  end
  assign stage_enable = stage_enable_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign err_stage = err_stage_q;
  assign overrun = overrun_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// tb_echo_pipeline_sequencer: directed bench with a ready responder and hand-computed timing
module tb_echo_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst, run, mode;
  logic [12:0] sc, counter;
  logic [4:0] stage_ready, stage_enable, prev_en;
  logic light, busy, frame_done, timeout_err, overrun;
  logic [3:0] err_stage;
  logic [31:0] frame_count;
  int n_chk = 0, n_err = 0, cyc = 0, w = 0, ov_cnt = 0;
  int seq[$], widths[$];
  int rcnt[5];
  bit armed[5], hold[5];

  always #5 clk = ~clk;

  echo_pipeline_sequencer #(.TIMEOUT(16)) dut (
    .clk_operation          (clk),
    .rst                    (rst),
    .run                    (run),
    .mode                   (mode),
    .sampling_cycle         (sc),
    .stage_ready            (stage_ready),
    .sampling_cycle_counter (counter),
    .sampling_light         (light),
    .stage_enable           (stage_enable),
    .busy                   (busy),
    .frame_done             (frame_done),
    .timeout_err            (timeout_err),
    .err_stage              (err_stage),
    .overrun                (overrun),
    .frame_count            (frame_count)
  );

  // each stage drops ready while enabled and raises it on the 3rd clock after the enable falls
  initial begin
    stage_ready = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (stage_enable[i]) begin
          stage_ready[i] = 1'b0;
          rcnt[i] = 0;
          armed[i] = 1'b1;
        end else if (armed[i]) begin
          rcnt[i]++;
          if (rcnt[i] == 3 && !hold[i]) begin
            stage_ready[i] = 1'b1;
            armed[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (overrun) ov_cnt++;
    if (stage_enable != 0) begin
      if (prev_en == 0)
        for (int i = 0; i < 5; i++) if (stage_enable[i]) seq.push_back(i);
      w++;
    end else if (prev_en != 0) begin
      widths.push_back(w);
      w = 0;
    end
    prev_en = stage_enable;
  endtask

  function automatic logic cond(input int s);
    case (s)
      0: return frame_done;
      1: return timeout_err;
      2: return busy;
      3: return stage_enable == 5'b00010;
      4: return counter == 0;
      5: return stage_enable != 0;
      6: return light;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int s, input int bound, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!cond(s) && n < bound);
    chk(tag, cond(s), 1);
  endtask

  function automatic int enc();
    int r = 0;
    foreach (seq[i]) r = (r << 4) | (seq[i] + 1);
    return r;
  endfunction

  function automatic int bad_widths();
    int b = 0;
    foreach (widths[i]) if (widths[i] != 2) b++;
    return b;
  endfunction

  initial begin
    rst = 1; run = 1; mode = 1; sc = 40; prev_en = '0;
    foreach (hold[i]) hold[i] = 0;
    repeat (3) tick();
    chk("rst_counter", counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", stage_enable, 0);
    chk("rst_fcount", frame_count, 0);
    chk("rst_err_stage", err_stage, 0);
    chk("rst_light", light, 0);
    // adapt frame: starts in the first clock after release (counter 0)
    rst = 0; cyc = 0; seq.delete(); widths.delete();
    tick();
    chk("start_counter", counter, 1);
    chk("start_busy", busy, 1);
    chk("start_enable_low", stage_enable, 0);
    tick();
    chk("first_enable", stage_enable, 5'b00001);
    tick();
    chk("first_enable_2nd", stage_enable, 5'b00001);
    tick();
    chk("first_enable_fall", stage_enable, 0);
    wait_for(0, 60, "adapt_done_seen");
    chk("adapt_done_time", cyc, 32);
    chk("adapt_busy_fall", busy, 0);
    chk("adapt_fcount", frame_count, 1);
    chk("adapt_seq", enc(), 32'h12345);
    chk("adapt_npulses", widths.size(), 5);
    chk("adapt_widths", bad_widths(), 0);
    tick();
    chk("done_one_pulse", frame_done, 0);
    // cancel frame; a mode flip after the start must not matter
    mode = 0; seq.delete(); widths.delete();
    wait_for(6, 20, "wrap_light_seen");
    chk("wrap_time", cyc, 40);
    chk("wrap_counter", counter, 0);
    wait_for(5, 10, "cancel_enable_seen");
    mode = 1;
    wait_for(0, 60, "cancel_done_seen");
    chk("cancel_done_time", cyc, 66);
    chk("cancel_seq", enc(), 32'h1235);
    chk("cancel_fcount", frame_count, 2);
    // timeout on stage 2
    wait_for(6, 30, "wrap2_seen");
    hold[2] = 1; seq.delete(); widths.delete();
    wait_for(1, 60, "timeout_seen");
    chk("timeout_time", cyc, 113);
    chk("timeout_err_stage", err_stage, 2);
    chk("timeout_fcount", frame_count, 2);
    chk("timeout_busy", busy, 0);
    chk("timeout_seq", enc(), 32'h123);
    tick();
    chk("timeout_one_pulse", timeout_err, 0);
    hold[2] = 0; seq.delete(); widths.delete();
    wait_for(0, 60, "recover_done_seen");
    chk("recover_done_time", cyc, 152);
    chk("recover_seq", enc(), 32'h12345);
    chk("recover_fcount", frame_count, 3);
    chk("err_stage_sticky", err_stage, 2);
    // short frame: shrinking sampling_cycle forces a wrap, then the frame overruns each wrap
    sc = 8;
    wait_for(2, 10, "short_busy_seen");
    chk("short_start_time", cyc, 154);
    ov_cnt = 0;
    wait_for(0, 60, "short_done_seen");
    chk("short_done_time", cyc, 185);
    chk("short_fcount", frame_count, 4);
    repeat (2) tick();
    chk("overrun_count", ov_cnt, 4);
    // reset while stage 1 is enabled
    wait_for(3, 40, "stage1_enable_seen");
    chk("stage1_time", cyc, 201);
    rst = 1;
    tick();
    chk("mid_rst_enable", stage_enable, 0);
    chk("mid_rst_counter", counter, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fcount", frame_count, 0);
    chk("mid_rst_err_stage", err_stage, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 0;
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_enable_low", stage_enable, 0);
    tick();
    chk("restart_enable", stage_enable, 5'b00001);
    // sampling_cycle of 1 behaves as 2
    sc = 1;
    wait_for(4, 10, "sc1_zero_seen");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sc1_counter", counter, (k % 2 == 0) ? 1 : 0);
      chk("sc1_light", light, (k % 2 == 0) ? 0 : 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
